fifo_byte_serializer: RTL and testbench

//  Drain stage on the read side of the 32-bit synchronous FIFO. It pops words

---
 rtl/fifo_ser_pkg.sv | 19 +
 rtl/fifo_byte_serializer_beat_mux.sv | 28 ++
 rtl/fifo_byte_serializer.sv | 101 ++++++++++
 tb/tb_fifo_byte_serializer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ser_pkg.sv
// Shared defaults and width helpers for the FIFO drain serializer.
// RATIO is the number of output beats that make up one FIFO word.
package fifo_ser_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_OUT_W  = 8;

  function automatic int ratio(input int data_w, input int out_w);
    return data_w / out_w;
  endfunction

  // A one-beat word still needs a 1-bit index so the vector is legal.
  function automatic int idx_w(input int data_w, input int out_w);
    int r;
    r = data_w / out_w;
    return (r > 1) ? $clog2(r) : 1;
  endfunction

endpackage

// File: rtl/fifo_byte_serializer_beat_mux.sv
// Selects the current OUT_W-bit beat out of a FIFO word from the beat index.
// LSB_FIRST picks whether beat 0 is the low or the high slice of the word.
module beat_mux
  import fifo_ser_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter bit LSB_FIRST = 1'b1,
  parameter int IDX_W     = idx_w(DEF_DATA_W, DEF_OUT_W)
) (
  input  logic [DATA_W-1:0] word,
  input  logic [IDX_W-1:0]  idx,
  output logic [OUT_W-1:0]  beat
);

  localparam int RATIO = ratio(DATA_W, OUT_W);

  always_comb begin
    // NOTE: default assigned first so every path drives beat and no latch is inferred.
    beat = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (idx == IDX_W'(i)) begin
        beat = word[(LSB_FIRST ? i : RATIO - 1 - i) * OUT_W +: OUT_W];
      end
    end
  end

endmodule

// File: rtl/fifo_byte_serializer.sv
// Read-side drain of the 32-bit FIFO: a one-word prefetch buffer feeds a
// shift stage that emits the word as OUT_W-bit beats on a valid/ready link.
module fifo_byte_serializer
  import fifo_ser_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              fifo_re,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [CNT_W-1:0]  words_done,
  output logic              busy
);

  localparam int RATIO = ratio(DATA_W, OUT_W);
  localparam int IDX_W = idx_w(DATA_W, OUT_W);

  logic              rd_pend;
  logic              pf_valid;
  logic [DATA_W-1:0] pf_data;
  logic              sr_valid;
  logic [DATA_W-1:0] sr_data;
  logic [IDX_W-1:0]  idx;

  logic accept;
  logic last_accept;
  logic load;

  // Only one read in flight, and only when the prefetch slot can take it.
  // Gated with reset so the FIFO is never popped while the block is held.
  assign fifo_re     = rst && !fifo_empty && !rd_pend && !pf_valid;

  assign out_valid   = sr_valid;
  assign out_last    = sr_valid && (idx == IDX_W'(RATIO - 1));
  assign busy        = rd_pend || pf_valid || sr_valid;

  assign accept      = out_valid && out_ready;
  assign last_accept = accept && out_last;
  assign load        = pf_valid && (!sr_valid || last_accept);

  beat_mux #(
    .DATA_W    (DATA_W),
    .OUT_W     (OUT_W),
    .LSB_FIRST (LSB_FIRST),
    .IDX_W     (IDX_W)
  ) u_beat_mux (
    .word (sr_data),
    .idx  (idx),
    .beat (out_data)
  );

  // A capture and a load never coincide: a read is only issued with pf empty,
  // so pf_valid is still clear on the cycle rd_pend delivers the word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend    <= 1'b0;
      pf_valid   <= 1'b0;
      sr_valid   <= 1'b0;
      idx        <= '0;
      words_done <= '0;
      // NOTE: the data words are reset too because out_data must read 0 in reset.
      pf_data    <= '0;
      sr_data    <= '0;
    end else begin
      // NOTE: non-blocking throughout so every flag sees the pre-edge state.
      rd_pend <= fifo_re;

      if (rd_pend) begin
        pf_data  <= fifo_dout;
        pf_valid <= 1'b1;
      end

      if (load) begin
        sr_data  <= pf_data;
        sr_valid <= 1'b1;
        idx      <= '0;
        pf_valid <= 1'b0;
      end else if (accept) begin
        if (out_last) begin
          sr_valid <= 1'b0;
        end else begin
          idx <= idx + 1'b1;
        end
      end

      if (last_accept) begin
        words_done <= words_done + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Directed bench for fifo_byte_serializer: two instances (LSB-first and
// MSB-first), each fed by a small registered-read FIFO model.
module tb_fifo_byte_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // LSB-first instance
  logic        fifo_re, fifo_empty, out_valid, out_ready, out_last, busy;
  logic [31:0] fifo_dout = '0;
  logic [7:0]  out_data;
  logic [15:0] words_done;

  // MSB-first instance
  logic        fifo_re_b, fifo_empty_b, out_valid_b, out_ready_b, out_last_b, busy_b;
  logic [31:0] fifo_dout_b = '0;
  logic [7:0]  out_data_b;
  logic [15:0] words_done_b;

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO models: words pushed by the stimulus tasks, popped on fifo_re with
  // data appearing the cycle after the read strike.
  logic [31:0] mem_a [0:31];
  logic [31:0] mem_b [0:31];
  int wr_a = 0, rd_a = 0, re_viol = 0;
  int wr_b = 0, rd_b = 0;

  assign fifo_empty   = (wr_a == rd_a);
  assign fifo_empty_b = (wr_b == rd_b);

  always @(posedge clk) begin
    if (fifo_re && fifo_empty) re_viol <= re_viol + 1;
    if (fifo_re) begin
      fifo_dout <= mem_a[rd_a];
      rd_a      <= rd_a + 1;
    end
  end

  always @(posedge clk) begin
    if (fifo_re_b) begin
      fifo_dout_b <= mem_b[rd_b];
      rd_b        <= rd_b + 1;
    end
  end

  fifo_byte_serializer #(.DATA_W(32), .OUT_W(8), .LSB_FIRST(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .fifo_re(fifo_re), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .words_done(words_done), .busy(busy)
  );

  fifo_byte_serializer #(.DATA_W(32), .OUT_W(8), .LSB_FIRST(1'b0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .fifo_re(fifo_re_b), .fifo_empty(fifo_empty_b), .fifo_dout(fifo_dout_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .out_last(out_last_b),
    .words_done(words_done_b), .busy(busy_b)
  );

  // Accepted beats captured by the collectors.
  logic [7:0] got_data [0:63];
  logic       got_last [0:63];
  int         got_cyc  [0:63];
  int         got_n;

  task automatic push_a(input logic [31:0] w);
    mem_a[wr_a] = w;
    wr_a = wr_a + 1;
  endtask

  task automatic push_b(input logic [31:0] w);
    mem_b[wr_b] = w;
    wr_b = wr_b + 1;
  endtask

  // Samples instance A #1 after each falling edge and records accepted beats.
  task automatic collect_a(input int n, input int budget);
    got_n = 0;
    for (int c = 0; c < budget && got_n < n; c++) begin
      @(negedge clk); #1;
      if (out_valid && out_ready) begin
        got_data[got_n] = out_data;
        got_last[got_n] = out_last;
        got_cyc[got_n]  = c;
        got_n++;
      end
    end
  endtask

  task automatic test_reset;
    out_ready = 1'b0;
    out_ready_b = 1'b0;
    push_a(32'hA1B2C3D4);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_checks++; if (fifo_re !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_re got=%b exp=0", fifo_re); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (words_done !== 16'd0) begin n_fail++; $display("FAIL reset_words_done got=%0d exp=0", words_done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (out_data !== 8'h00 || out_last !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_data got=%h/%b exp=00/0", out_data, out_last);
    end
    rst = 1'b1;
    #1;
    n_checks++; if (fifo_re !== 1'b1) begin n_fail++; $display("FAIL release_fifo_re got=%b exp=1", fifo_re); end
  endtask

  task automatic test_single_word;
    logic [7:0] exp [0:3];
    exp[0] = 8'hD4; exp[1] = 8'hC3; exp[2] = 8'hB2; exp[3] = 8'hA1;
    out_ready = 1'b1;
    collect_a(4, 20);
    n_checks++; if (got_n !== 4) begin n_fail++; $display("FAIL single_beat_count got=%0d exp=4", got_n); end
    for (int i = 0; i < got_n && i < 4; i++) begin
      n_checks++; if (got_data[i] !== exp[i]) begin n_fail++; $display("FAIL single_beat%0d got=%h exp=%h", i, got_data[i], exp[i]); end
      n_checks++; if (got_last[i] !== (i == 3)) begin n_fail++; $display("FAIL single_last%0d got=%b exp=%b", i, got_last[i], (i == 3)); end
      n_checks++; if (got_cyc[i] !== got_cyc[0] + i) begin n_fail++; $display("FAIL single_gap%0d got=%0d exp=%0d", i, got_cyc[i], got_cyc[0] + i); end
    end
    @(negedge clk); #1;
    n_checks++; if (words_done !== 16'd1) begin n_fail++; $display("FAIL single_words_done got=%0d exp=1", words_done); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle got=%b exp=0", out_valid); end
  endtask

  task automatic test_streaming;
    logic [31:0] w [0:7];
    logic [7:0]  e;
    for (int i = 0; i < 8; i++) begin
      w[i] = {8'h40 + 8'(i), 8'h30 + 8'(i), 8'h20 + 8'(i), 8'h10 + 8'(i)};
      push_a(w[i]);
    end
    out_ready = 1'b1;
    collect_a(32, 120);
    n_checks++; if (got_n !== 32) begin n_fail++; $display("FAIL stream_beat_count got=%0d exp=32", got_n); end
    for (int i = 0; i < got_n && i < 32; i++) begin
      e = w[i / 4][(i % 4) * 8 +: 8];
      n_checks++; if (got_data[i] !== e) begin n_fail++; $display("FAIL stream_beat%0d got=%h exp=%h", i, got_data[i], e); end
      n_checks++; if (got_last[i] !== (i % 4 == 3)) begin n_fail++; $display("FAIL stream_last%0d got=%b exp=%b", i, got_last[i], (i % 4 == 3)); end
      n_checks++; if (got_cyc[i] !== got_cyc[0] + i) begin n_fail++; $display("FAIL stream_gap%0d got=%0d exp=%0d", i, got_cyc[i], got_cyc[0] + i); end
    end
    @(negedge clk); #1;
    n_checks++; if (words_done !== 16'd9) begin n_fail++; $display("FAIL stream_words_done got=%0d exp=9", words_done); end
    n_checks++; if (re_viol !== 0) begin n_fail++; $display("FAIL stream_re_while_empty got=%0d exp=0", re_viol); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stream_busy got=%b exp=0", busy); end
  endtask

  task automatic test_backpressure;
    logic [7:0] exp [0:3];
    logic [7:0] prev_data;
    logic       prev_last;
    bit         pending;
    int         extra;
    exp[0] = 8'h04; exp[1] = 8'h03; exp[2] = 8'h02; exp[3] = 8'h01;
    pending = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    push_a(32'h01020304);
    got_n = 0;
    for (int c = 0; c < 60 && got_n < 4; c++) begin
      @(negedge clk);
      out_ready = (c % 3 == 0);
      #1;
      if (pending) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
          n_fail++; $display("FAIL bp_hold cyc%0d got=%b/%h/%b exp=1/%h/%b", c, out_valid, out_data, out_last, prev_data, prev_last);
        end
      end
      if (out_valid && out_ready) begin
        got_data[got_n] = out_data;
        got_last[got_n] = out_last;
        got_n++;
        pending = 1'b0;
      end else if (out_valid) begin
        pending   = 1'b1;
        prev_data = out_data;
        prev_last = out_last;
      end
    end
    n_checks++; if (got_n !== 4) begin n_fail++; $display("FAIL bp_beat_count got=%0d exp=4", got_n); end
    for (int i = 0; i < got_n && i < 4; i++) begin
      n_checks++; if (got_data[i] !== exp[i]) begin n_fail++; $display("FAIL bp_beat%0d got=%h exp=%h", i, got_data[i], exp[i]); end
      n_checks++; if (got_last[i] !== (i == 3)) begin n_fail++; $display("FAIL bp_last%0d got=%b exp=%b", i, got_last[i], (i == 3)); end
    end
    out_ready = 1'b1;
    extra = 0;
    repeat (4) begin
      @(negedge clk); #1;
      if (out_valid) extra++;
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL bp_extra_beats got=%0d exp=0", extra); end
    n_checks++; if (words_done !== 16'd10) begin n_fail++; $display("FAIL bp_words_done got=%0d exp=10", words_done); end
  endtask

  task automatic test_msb_order;
    logic [7:0] exp [0:3];
    logic [7:0] gd [0:3];
    logic       gl [0:3];
    int         n;
    exp[0] = 8'hDE; exp[1] = 8'hAD; exp[2] = 8'hBE; exp[3] = 8'hEF;
    push_b(32'hDEADBEEF);
    out_ready_b = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      @(negedge clk); #1;
      if (out_valid_b && out_ready_b) begin
        gd[n] = out_data_b;
        gl[n] = out_last_b;
        n++;
      end
    end
    n_checks++; if (n !== 4) begin n_fail++; $display("FAIL msb_beat_count got=%0d exp=4", n); end
    for (int i = 0; i < n && i < 4; i++) begin
      n_checks++; if (gd[i] !== exp[i]) begin n_fail++; $display("FAIL msb_beat%0d got=%h exp=%h", i, gd[i], exp[i]); end
      n_checks++; if (gl[i] !== (i == 3)) begin n_fail++; $display("FAIL msb_last%0d got=%b exp=%b", i, gl[i], (i == 3)); end
    end
    @(negedge clk); #1;
    n_checks++; if (words_done_b !== 16'd1) begin n_fail++; $display("FAIL msb_words_done got=%0d exp=1", words_done_b); end
    n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL msb_busy got=%b exp=0", busy_b); end
  endtask

  task automatic test_reset_mid_word;
    bit found;
    int seen;
    out_ready = 1'b1;
    push_a(32'h11223344);
    push_a(32'h55667788);
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk); #1;
      if (out_valid && out_data == 8'h22) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL mid_beat2_seen got=0 exp=1"); end
    @(negedge clk); #1;
    n_checks++; if (out_data !== 8'h11) begin n_fail++; $display("FAIL mid_beat3 got=%h exp=11", out_data); end
    n_checks++; if (rd_a !== wr_a || busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_second_word_taken got=%0d/%b exp=%0d/1", rd_a, busy, wr_a);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      n_fail++; $display("FAIL mid_async_valid got=%b/%b exp=0/0", out_valid, out_last);
    end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL mid_async_data got=%h exp=00", out_data); end
    n_checks++; if (busy !== 1'b0 || fifo_re !== 1'b0) begin
      n_fail++; $display("FAIL mid_async_busy got=%b/%b exp=0/0", busy, fifo_re);
    end
    n_checks++; if (words_done !== 16'd0) begin n_fail++; $display("FAIL mid_async_words_done got=%0d exp=0", words_done); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk); #1;
      if (out_valid) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL mid_residual_beats got=%0d exp=0", seen); end
    n_checks++; if (words_done !== 16'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_after_release got=%0d/%b exp=0/0", words_done, busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    out_ready   = 1'b0;
    out_ready_b = 1'b0;
    test_reset;
    test_single_word;
    test_streaming;
    test_backpressure;
    test_msb_order;
    test_reset_mid_word;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
